// File: rtl/tiny_io_scheduler_if.sv
// Wishbone classic slave bundle for the tiny I/O scheduler register file.
// Signal names keep the Caravel wbs_* suffixes so the wrapper wiring stays obvious.
interface tiny_io_scheduler_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic [3:0]  wbs_sel_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/tiny_io_scheduler.sv
// Time-shares the user pads among N_PROJ tiny projects; every switch runs
// isolate -> reset -> run so pads never see two drivers and projects start clean.
module tiny_io_scheduler #(
   parameter int N_PROJ  = 4,
   parameter int IO_W    = 38,
   parameter int GUARD   = 4,
   parameter int RST_CYC = 8
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_ni,
   tiny_io_scheduler_if.slave     wb,
   input  logic [IO_W-1:0]        io_in,
   output logic [IO_W-1:0]        io_out,
   output logic [IO_W-1:0]        io_oeb,
   output logic [N_PROJ*IO_W-1:0] prj_io_in,
   input  logic [N_PROJ*IO_W-1:0] prj_io_out,
   input  logic [N_PROJ*IO_W-1:0] prj_io_oeb,
   output logic [N_PROJ-1:0]      prj_ena,
   output logic [N_PROJ-1:0]      prj_rst_n,
   output logic                   user_irq
);

   typedef enum logic [1:0] {
      ST_ISOLATE = 2'd0,
      ST_RESET   = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   localparam int CNT_MAX = (GUARD > RST_CYC) ? GUARD : RST_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    target, target_n;
   logic [3:0]    active, active_n;
   logic [31:0]   dwell_cnt, dwell_cnt_n;
   logic          irq_n;

   logic [3:0]    sel_r;
   logic          auto_r;
   logic [31:0]   dwell_r;

   logic          wb_req, wr_en, sel_ok, ctrl_switch, dwell_wr;
   logic [1:0]    idx;
   logic [31:0]   rd_data;
   logic [4:0]    rr_inc;
   logic [3:0]    rr_next;
   logic          unused_adr;

   assign unused_adr  = ^{wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0]};
   assign idx         = wb.wbs_adr_i[3:2];
   // Ack toggles off for a cycle after every beat, so a held strobe acks every other cycle.
   assign wb_req      = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o;
   assign wr_en       = wb_req & wb.wbs_we_i;
   assign sel_ok      = ({1'b0, wb.wbs_dat_i[3:0]} < 5'(N_PROJ));
   assign ctrl_switch = wr_en && (idx == 2'd0) && wb.wbs_sel_i[0] && sel_ok;
   assign dwell_wr    = wr_en && (idx == 2'd1);
   assign rr_inc      = {1'b0, active} + 5'd1;
   assign rr_next     = (rr_inc == 5'(N_PROJ)) ? 4'd0 : rr_inc[3:0];

   always_comb begin
      rd_data = '0;
      case (idx)
         2'd0:    rd_data = {23'd0, auto_r, 4'd0, sel_r};
         2'd1:    rd_data = dwell_r;
         2'd2:    rd_data = {25'd0, (state != ST_RUN), state, active};
         default: rd_data = '0;
      endcase
   end

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      target_n    = target;
      active_n    = active;
      dwell_cnt_n = dwell_cnt;
      irq_n       = 1'b0;
      case (state)
         ST_ISOLATE: begin
            if (cnt == CW'(GUARD - 1)) begin
               state_n  = ST_RESET;
               cnt_n    = '0;
               active_n = target;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_RESET: begin
            if (cnt == CW'(RST_CYC - 1)) begin
               state_n     = ST_RUN;
               cnt_n       = '0;
               dwell_cnt_n = '0;
               irq_n       = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_RUN: begin
            if (auto_r && (dwell_r != 32'd0)) begin
               if (dwell_cnt == dwell_r - 32'd1) begin
                  state_n     = ST_ISOLATE;
                  cnt_n       = '0;
                  target_n    = rr_next;
                  dwell_cnt_n = '0;
               end else begin
                  dwell_cnt_n = dwell_cnt + 32'd1;
               end
            end else begin
               dwell_cnt_n = '0;
            end
         end
         default: begin
            state_n = ST_ISOLATE;
            cnt_n   = '0;
         end
      endcase
      if (dwell_wr) dwell_cnt_n = '0;
      // A host write outranks a same-cycle dwell expiry.
      if (ctrl_switch) begin
         state_n     = ST_ISOLATE;
         cnt_n       = '0;
         target_n    = wb.wbs_dat_i[3:0];
         dwell_cnt_n = '0;
         irq_n       = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state        <= ST_ISOLATE;
         cnt          <= '0;
         target       <= '0;
         active       <= '0;
         dwell_cnt    <= '0;
         user_irq     <= 1'b0;
         sel_r        <= '0;
         auto_r       <= 1'b0;
         dwell_r      <= '0;
         wb.wbs_ack_o <= 1'b0;
         wb.wbs_dat_o <= '0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         target       <= target_n;
         active       <= active_n;
         dwell_cnt    <= dwell_cnt_n;
         user_irq     <= irq_n;
         wb.wbs_ack_o <= wb_req;
         wb.wbs_dat_o <= (wb_req && !wb.wbs_we_i) ? rd_data : 32'd0;
         if (wr_en && (idx == 2'd0)) begin
            if (wb.wbs_sel_i[0] && sel_ok) sel_r  <= wb.wbs_dat_i[3:0];
            if (wb.wbs_sel_i[1])           auto_r <= wb.wbs_dat_i[8];
         end
         for (int b = 0; b < 4; b++) begin
            if (dwell_wr && wb.wbs_sel_i[b]) dwell_r[8*b +: 8] <= wb.wbs_dat_i[8*b +: 8];
         end
      end
   end

   // Pad mux is purely combinational from registered state; outside RUN pads are inputs.
   always_comb begin
      io_out    = '0;
      io_oeb    = '1;
      prj_io_in = '0;
      prj_ena   = '0;
      prj_rst_n = '0;
      for (int k = 0; k < N_PROJ; k++) begin
         if (active == 4'(k)) begin
            prj_ena[k] = (state != ST_ISOLATE);
            if (state == ST_RUN) begin
               prj_rst_n[k]                = 1'b1;
               io_out                      = prj_io_out[k*IO_W +: IO_W];
               io_oeb                      = prj_io_oeb[k*IO_W +: IO_W];
               prj_io_in[k*IO_W +: IO_W]   = io_in;
            end
         end
      end
   end

endmodule

// File: tb/tb_tiny_io_scheduler.sv
// Directed bench for tiny_io_scheduler: switch timing, auto-rotation, register file
// and async reset, with read data checked through an expected-value queue.
module tb_tiny_io_scheduler;
   localparam int N = 4;
   localparam int W = 38;
   localparam int G = 4;
   localparam int R = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [W-1:0]   io_in, io_out, io_oeb;
   logic [N*W-1:0] prj_io_in, prj_io_out, prj_io_oeb;
   logic [N-1:0]   prj_ena, prj_rst_n;
   logic           user_irq;

   int             checks = 0;
   int             errors = 0;
   logic [31:0]    exp_q[$];

   tiny_io_scheduler_if wb ();

   tiny_io_scheduler #(.N_PROJ(N), .IO_W(W), .GUARD(G), .RST_CYC(R)) dut (
      .wb_clk_i   (clk),
      .wb_rst_ni  (rst_n),
      .wb         (wb.slave),
      .io_in      (io_in),
      .io_out     (io_out),
      .io_oeb     (io_oeb),
      .prj_io_in  (prj_io_in),
      .prj_io_out (prj_io_out),
      .prj_io_oeb (prj_io_oeb),
      .prj_ena    (prj_ena),
      .prj_rst_n  (prj_rst_n),
      .user_irq   (user_irq)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] pat(int k);
      return 38'h15_A5A5_3C3C ^ (38'(k) * 38'h03_0F0F_1111);
   endfunction

   function automatic logic [W-1:0] oeb_pat(int k);
      return ~pat(k) ^ 38'h00_0000_00F1;
   endfunction

   function automatic logic [N*W-1:0] exp_in(int k);
      logic [N*W-1:0] v;
      v = '0;
      v[k*W +: W] = io_in;
      return v;
   endfunction

   task automatic check(string tag, logic [159:0] obs, logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_iso(string tag);
      check({tag, "_oeb"}, io_oeb, {W{1'b1}});
      check({tag, "_out"}, io_out, '0);
      check({tag, "_rstn"}, prj_rst_n, '0);
      check({tag, "_ena"}, prj_ena, '0);
      check({tag, "_pin"}, prj_io_in, '0);
   endtask

   task automatic expect_rst(int k, string tag);
      logic [N-1:0] oh;
      oh = 4'b0001 << k;
      check({tag, "_oeb"}, io_oeb, {W{1'b1}});
      check({tag, "_out"}, io_out, '0);
      check({tag, "_rstn"}, prj_rst_n, '0);
      check({tag, "_ena"}, prj_ena, oh);
   endtask

   task automatic expect_run(int k, string tag);
      logic [N-1:0] oh;
      oh = 4'b0001 << k;
      check({tag, "_rstn"}, prj_rst_n, oh);
      check({tag, "_ena"}, prj_ena, oh);
      check({tag, "_out"}, io_out, pat(k));
      check({tag, "_oeb"}, io_oeb, oeb_pat(k));
      check({tag, "_pin"}, prj_io_in, exp_in(k));
   endtask

   // Current cycle is the first ISOLATE cycle; ends in the first RUN cycle.
   task automatic switch_seq(int k, string tag);
      for (int c = 0; c < G + R; c++) begin
         if (c > 0) tick();
         if (c < G) expect_iso({tag, "_iso"});
         else       expect_rst(k, {tag, "_rst"});
      end
      check({tag, "_irq_pre"}, user_irq, 1'b0);
      tick();
      expect_run(k, {tag, "_run"});
      check({tag, "_irq"}, user_irq, 1'b1);
   endtask

   task automatic wb_idle();
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_stb_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
      wb.wbs_adr_i = '0;
      wb.wbs_dat_i = '0;
      wb.wbs_sel_i = '0;
   endtask

   // Returns in the cycle where ack is high (strobes already dropped).
   task automatic wb_write(logic [31:0] adr, logic [31:0] dat, logic [3:0] sel);
      int n;
      wb.wbs_cyc_i = 1'b1;
      wb.wbs_stb_i = 1'b1;
      wb.wbs_we_i  = 1'b1;
      wb.wbs_adr_i = adr;
      wb.wbs_dat_i = dat;
      wb.wbs_sel_i = sel;
      n = 0;
      do begin
         tick();
         n++;
      end while (!wb.wbs_ack_o && n < 4);
      check("wr_ack_latency", n, 1);
      wb_idle();
   endtask

   task automatic wb_read(logic [31:0] adr, logic [31:0] exp);
      int n;
      wb.wbs_cyc_i = 1'b1;
      wb.wbs_stb_i = 1'b1;
      wb.wbs_we_i  = 1'b0;
      wb.wbs_adr_i = adr;
      wb.wbs_sel_i = 4'hF;
      exp_q.push_back(exp);
      n = 0;
      do begin
         tick();
         n++;
      end while (!wb.wbs_ack_o && n < 4);
      check("rd_ack_latency", n, 1);
      if (wb.wbs_ack_o) check("rd_data", wb.wbs_dat_o, exp_q.pop_front());
      else              void'(exp_q.pop_front());
      wb_idle();
      tick();
      check("rd_ack_single", wb.wbs_ack_o, 1'b0);
      check("rd_dat_idle", wb.wbs_dat_o, 32'd0);
   endtask

   initial begin
      wb_idle();
      io_in = 38'h2A_1234_5678;
      for (int k = 0; k < N; k++) begin
         prj_io_out[k*W +: W] = pat(k);
         prj_io_oeb[k*W +: W] = oeb_pat(k);
      end

      // Held in reset
      tick();
      tick();
      expect_iso("reset");
      check("reset_ack", wb.wbs_ack_o, 1'b0);
      check("reset_dat", wb.wbs_dat_o, 32'd0);
      check("reset_irq", user_irq, 1'b0);

      // Release: project 0 runs in cycle 12
      rst_n = 1'b1;
      switch_seq(0, "boot");
      tick();
      check("boot_irq_pulse", user_irq, 1'b0);
      expect_run(0, "boot_hold");

      // Manual switch to project 2
      wb_write(32'h0, 32'h2, 4'hF);
      switch_seq(2, "sel2");
      wb_read(32'h8, 32'h22);

      // Out-of-range SEL: no switch, AUTO still written
      wb_write(32'h0, 32'h105, 4'hF);
      expect_run(2, "sel5_ack");
      tick();
      expect_run(2, "sel5_hold");
      wb_read(32'h0, 32'h102);

      // Auto rotation from project 3 wraps to project 0 after 20 RUN cycles
      wb_write(32'h4, 32'd20, 4'hF);
      tick();
      wb_write(32'h0, 32'h103, 4'hF);
      switch_seq(3, "auto3");
      for (int d = 1; d < 20; d++) begin
         tick();
         check("auto3_dwell_rstn", prj_rst_n, 4'b1000);
      end
      tick();
      switch_seq(0, "wrap0");

      // Rewrite during RESET toward project 2: restart toward project 1
      wb_write(32'h0, 32'h2, 4'hF);
      for (int c = 1; c <= G + 1; c++) begin
         tick();
         if (c < G) expect_iso("abort_iso");
         else       expect_rst(2, "abort_rst");
      end
      wb_write(32'h0, 32'h1, 4'hF);
      switch_seq(1, "sel1");
      check("p2_never_run", prj_rst_n[2], 1'b0);
      wb_read(32'h8, 32'h21);

      // Register file details
      wb_read(32'h4, 32'd20);
      wb_read(32'h0, 32'h001);
      wb_write(32'hC, 32'hDEAD_BEEF, 4'hF);
      tick();
      wb_read(32'hC, 32'h0);
      wb_write(32'h4, 32'hFFFF_FF05, 4'b0001);
      tick();
      wb_read(32'h4, 32'h5);
      expect_run(1, "regs_hold");

      // Async reset asserted while ack is high
      wb.wbs_cyc_i = 1'b1;
      wb.wbs_stb_i = 1'b1;
      wb.wbs_adr_i = 32'h8;
      tick();
      check("pre_rst_ack", wb.wbs_ack_o, 1'b1);
      rst_n = 1'b0;
      #1;
      expect_iso("async_rst");
      check("async_rst_ack", wb.wbs_ack_o, 1'b0);
      check("async_rst_dat", wb.wbs_dat_o, 32'd0);
      wb_idle();
      tick();
      rst_n = 1'b1;
      tick();
      check("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/tiny_io_scheduler.md
# tiny_io_scheduler

Time-shares the 38 Caravel user I/O pads among `N_PROJ` tiny projects placed inside `user_project_wrapper`. A Wishbone-slave register file selects the active project, either manually or by round-robin auto-rotation. Every switch runs a fixed isolate → reset → run sequence, so pads never glitch between two drivers and each newly selected project starts from reset.

## Interface
- `N_PROJ`, 4: number of tiny projects sharing the pads (2..16).
- `IO_W`, 38: pad count.
- `GUARD`, 4: cycles all pads are held as inputs (oeb=1) during a switch (≥1).
- `RST_CYC`, 8: cycles the target project is held in reset before connection (≥1).
- `wb_clk_i  in  1  single clock for all logic`
- `wb_rst_ni  in  1  asynchronous, active-low reset`
- `wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobes`
- `wbs_adr_i  in  32  byte address; only [3:2] decoded`
- `wbs_dat_i  in  32  write data`
- `wbs_sel_i  in  4  byte enables`
- `wbs_ack_o  out  1  single-cycle acknowledge`
- `wbs_dat_o  out  32  read data`
- `io_in  in  IO_W  from pads`
- `io_out / io_oeb  out  IO_W each  to pads`
- `prj_io_in  out  N_PROJ*IO_W  per-project pad inputs (project k at [k*IO_W +: IO_W])`
- `prj_io_out / prj_io_oeb  in  N_PROJ*IO_W each  per-project pad drives`
- `prj_ena  out  N_PROJ  one-hot clock-enable of the selected project`
- `prj_rst_n  out  N_PROJ  per-project active-low reset`
- `user_irq  out  1  one-cycle pulse on entry to RUN`

## Operation
- Registers (word index = `wbs_adr_i[3:2]`; writes honour `wbs_sel_i` per byte):
  - 0 CTRL: [3:0] SEL, [8] AUTO.
  - 1 DWELL: 32-bit auto-rotation period in cycles; 0 means hold.
  - 2 STATUS (read-only): [3:0] active index, [5:4] state (0 ISOLATE, 1 RESET, 2 RUN), [6] busy = state≠RUN.
  - 3 reads as 0; writes are ignored.
- A CTRL write with byte 0 enabled and SEL < N_PROJ sets target = SEL and restarts the sequence at ISOLATE with count 0. This applies in any state, including a rewrite of the current SEL, which acts as a soft reset. If SEL ≥ N_PROJ, the SEL field is ignored, no switch occurs, and AUTO is still written.
- FSM states:
  - ISOLATE: io_oeb all 1, io_out 0, all prj_rst_n 0, prj_ena 0. Lasts GUARD cycles, then goes to RESET; active index takes the target value.
  - RESET: prj_ena[active]=1, prj_rst_n all 0, pads still isolated. Lasts RST_CYC cycles, then goes to RUN.
  - RUN: prj_rst_n[active]=1 and prj_ena[active]=1. io_out and io_oeb come from project `active`. prj_io_in[active] = io_in; all other prj_io_in slices are 0.
- Auto mode: in RUN with AUTO=1 and DWELL≠0, a dwell counter starts at 0 on RUN entry and increments each cycle. When it reaches DWELL−1, target = (active+1) mod N_PROJ and the FSM goes to ISOLATE. Clearing AUTO, or writing DWELL, resets the dwell counter.
- Unselected projects always have prj_rst_n=0 and prj_ena=0.

## Timing
- Reset (async assert, sync-released on the clock): wbs_ack_o=0, wbs_dat_o=0, io_oeb all 1, io_out 0, prj_rst_n 0, prj_ena 0, user_irq 0, SEL=0, AUTO=0, DWELL=0. State = ISOLATE, count 0, target 0.
- Wishbone:
  - wbs_ack_o rises one cycle after cyc&stb and stays high for exactly one cycle. It then stays low for one cycle before it can ack again.
  - Write side effects commit on the edge that raises ack.
  - wbs_dat_o is valid only while ack is high and is 0 otherwise.
- Switch latency:
  - The first ISOLATE cycle is the cycle in which ack is high, or the first cycle after reset release.
  - RUN is entered exactly GUARD+RST_CYC cycles later.
  - user_irq is high during the first RUN cycle.
- The pad mux is combinational from registered state. Pads carry no project data in any cycle whose state is not RUN.
- Simultaneous events: a CTRL write in the same cycle as dwell expiry wins, so the target is the written SEL. Reset asserted mid-sequence immediately forces the reset values.

## Test plan
- Reset release, defaults: io_oeb=all 1 for 12 cycles. In cycle 12: prj_rst_n=4'b0001, user_irq pulses, io_out mirrors prj_io_out[0].
- Write CTRL SEL=2: pads isolated with prj_rst_n=0 for 4 cycles. prj_ena=4'b0100 for the next 8 cycles. RUN follows. STATUS reads active=2, busy=0.
- Write SEL=5 with AUTO=1: no switch. CTRL readback shows SEL unchanged and AUTO=1.
- AUTO=1, DWELL=20 from project 3: after 20 RUN cycles, the FSM switches to project 0 (wrap). RUN on project 0 is entered 12 cycles later.
- A write of SEL=1 during RESET toward project 2: the count restarts, and RUN on project 1 is entered 12 cycles after the ack. Project 2 never leaves reset.
- wb_rst_ni asserted during RUN: the same cycle shows io_oeb=all 1, prj_rst_n=0, prj_ena=0, and wbs_ack_o=0.
